// File: rtl/credit_link_tx_if.sv
// Local word handshake, link beat and credit signals of credit_link_tx.
// The master modport is the transmitter's view; slave is the surrounding environment.
interface credit_link_tx_if #(
    parameter int Width   = 16,
    parameter int Credits = 4
);
    localparam int CreditW = $clog2(Credits + 1);

    logic               clr;
    logic               wvalid;
    logic               wready;
    logic [Width-1:0]   wdata;
    logic               tx_valid;
    logic [Width-1:0]   tx_data;
    logic               credit_ret;
    logic [CreditW-1:0] credits;
    logic               clr_done;
    logic               err;

    modport master (
        input  clr,
        input  wvalid,
        output wready,
        input  wdata,
        output tx_valid,
        output tx_data,
        input  credit_ret,
        output credits,
        output clr_done,
        output err
    );

    modport slave (
        output clr,
        output wvalid,
        input  wready,
        output wdata,
        input  tx_valid,
        input  tx_data,
        output credit_ret,
        input  credits,
        input  clr_done,
        input  err
    );
endinterface

// File: rtl/credit_link_tx.sv
// Credit-flow-controlled link transmitter with a flush (drain-then-resume) sequence.
// Define CREDIT_LINK_TX_ERR_CHECK_EN to build the sticky credit-overflow flag on err.
module credit_link_tx #(
    parameter int Width   = 16,
    parameter int Credits = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    credit_link_tx_if.master bus
);
    localparam int CreditW = $clog2(Credits + 1);
    localparam logic [CreditW-1:0] CreditsFull = CreditW'(Credits);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CreditW-1:0] credits_q, credits_d;
    logic               tx_valid_q;
    logic [Width-1:0]   tx_data_q;
    logic               wready;
    logic               send;
    logic               overflow;

    // Ready never looks at wvalid, so upstream may wait for it before asserting valid.
    assign wready   = (state_q == ST_ACTIVE) && (credits_q != '0) && !bus.clr;
    assign send     = bus.wvalid && wready;
    assign overflow = bus.credit_ret && !send && (credits_q == CreditsFull);

    // Send and return cancel; an unexpected return at full count is dropped.
    always_comb begin
        credits_d = credits_q;
        if (!overflow) begin
            credits_d = credits_q + CreditW'(bus.credit_ret) - CreditW'(send);
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_ACTIVE: if (bus.clr) state_d = ST_DRAIN;
            ST_DRAIN:  if (credits_d == CreditsFull) state_d = ST_DONE;
            ST_DONE:   state_d = ST_ACTIVE;
            default:   state_d = ST_ACTIVE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_ACTIVE;
            credits_q  <= CreditsFull;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            credits_q  <= credits_d;
            tx_valid_q <= send;
            if (send) begin
                tx_data_q <= bus.wdata;
            end
        end
    end

`ifdef CREDIT_LINK_TX_ERR_CHECK_EN
    logic err_q;

    // No send is possible outside ACTIVE, so a return at full count in DONE is caught here too.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (overflow) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.wready   = wready;
    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.credits  = credits_q;
    assign bus.clr_done = (state_q == ST_DONE);

endmodule
